// File: rtl/sram_frame_writer.sv
// sram_frame_writer: accepts shaded pixels from the ray-tracing pipeline,
// converts (x,y) to a linear framebuffer address, queues writes in a small
// FIFO and hands them to the SRAM arbiter over a req/grant handshake. After
// a frame completes, the write/read buffer offsets swap on the next vsync
// edge, so the display side never shows a partially drawn frame.
//
// Ports:
//   clk_in, reset_btn               clock, async active-high reset
//   pix_valid/pix_ready             pixel handshake from the pipeline
//   pix_x, pix_y, pix_rgb, pix_last pixel payload; pix_last ends a frame
//   sram_wr_req/sram_wr_grant       write handshake with the SRAM arbiter
//   sram_wr_addr, sram_wr_data      FIFO head: {offset, linear}, {8'h00, rgb}
//   vsync_in                        asynchronous vsync from the VGA domain
//   wr_addr_offset, rd_addr_offset  buffer being written / being displayed
//   frame_done                      one-cycle pulse on buffer swap
//   oor_err                         sticky out-of-range coordinate flag
module sram_frame_writer #(
  parameter int unsigned H_RES      = 800,
  parameter int unsigned V_RES      = 600,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter bit          VS_ACTIVE  = 1'b1
) (
  input  logic        clk_in,
  input  logic        reset_btn,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [23:0] pix_rgb,
  input  logic        pix_last,
  output logic        sram_wr_req,
  input  logic        sram_wr_grant,
  output logic [19:0] sram_wr_addr,
  output logic [31:0] sram_wr_data,
  input  logic        vsync_in,
  output logic        wr_addr_offset,
  output logic        rd_addr_offset,
  output logic        frame_done,
  output logic        oor_err
);

  localparam int unsigned LIN_W = 19;
  localparam int unsigned RGB_W = 24;
  localparam int unsigned ENT_W = 1 + LIN_W + RGB_W;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    DRAIN   = 2'd1,
    WAIT_VS = 2'd2,
    SWAP    = 2'd3
  } state_t;

  state_t state, state_n;

  // Stage 1 register: address computed, pushed (or dropped) on the next cycle
  logic             s1_valid;
  logic             s1_oor;
  logic [LIN_W-1:0] s1_lin;
  logic [RGB_W-1:0] s1_rgb;

  // Write FIFO; entry = {offset, linear, rgb}
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_n;

  logic vs_meta, vs_sync, vs_prev;

  logic             accept;
  logic             pix_oor;
  logic [LIN_W-1:0] pix_lin;
  logic             push;
  logic             pop;
  logic             vs_rise;
  logic             ready_n;
  logic             frame_done_n;
  logic [ENT_W-1:0] head;

  // Datapath combinational terms
  always_comb begin
    accept  = pix_valid && pix_ready;
    pix_oor = (32'(pix_x) >= H_RES) || (32'(pix_y) >= V_RES);
    pix_lin = LIN_W'(LIN_W'(pix_y) * LIN_W'(H_RES)) + LIN_W'(pix_x);
    push    = s1_valid && !s1_oor;
    pop     = (count != '0) && sram_wr_grant;
    count_n = count + CW'(push) - CW'(pop);
    vs_rise = (vs_sync == VS_ACTIVE) && (vs_prev != VS_ACTIVE);
    head    = mem[rd_ptr];
  end

  // Next state; ready is registered from next-cycle occupancy so it matches
  // (state==FILL) && (fifo_count + stage1_valid < FIFO_DEPTH) every cycle
  always_comb begin
    state_n      = state;
    ready_n      = 1'b0;
    frame_done_n = 1'b0;
    case (state)
      FILL:    if (accept && pix_last) state_n = DRAIN;
      DRAIN:   if (!s1_valid && (count == '0)) state_n = WAIT_VS;
      WAIT_VS: if (vs_rise) state_n = SWAP;
      SWAP:    state_n = FILL;
      default: state_n = FILL;
    endcase
    ready_n      = (state_n == FILL) &&
                   ((count_n + CW'(accept)) < CW'(FIFO_DEPTH));
    frame_done_n = (state_n == SWAP);
  end

  // State, control outputs and offsets
  always_ff @(posedge clk_in or posedge reset_btn) begin
    if (reset_btn) begin
      state          <= FILL;
      pix_ready      <= 1'b0;
      frame_done     <= 1'b0;
      oor_err        <= 1'b0;
      wr_addr_offset <= 1'b1;
      rd_addr_offset <= 1'b0;
      sram_wr_req    <= 1'b0;
    end else begin
      state       <= state_n;
      pix_ready   <= ready_n;
      frame_done  <= frame_done_n;
      sram_wr_req <= (count_n != '0);
      if (accept && pix_oor) oor_err <= 1'b1;
      // Offsets flip on entry to SWAP, coincident with the frame_done pulse
      if (frame_done_n) begin
        wr_addr_offset <= ~wr_addr_offset;
        rd_addr_offset <= ~rd_addr_offset;
      end
    end
  end

  // Stage 1 address register
  always_ff @(posedge clk_in or posedge reset_btn) begin
    if (reset_btn) begin
      s1_valid <= 1'b0;
      s1_oor   <= 1'b0;
      s1_lin   <= '0;
      s1_rgb   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_oor <= pix_oor;
        s1_lin <= pix_lin;
        s1_rgb <= pix_rgb;
      end
    end
  end

  // FIFO storage and pointers; reset so the head reads zero after reset
  always_ff @(posedge clk_in or posedge reset_btn) begin
    if (reset_btn) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {wr_addr_offset, s1_lin, s1_rgb};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
    end
  end

  // vsync synchronizer and edge history
  always_ff @(posedge clk_in or posedge reset_btn) begin
    if (reset_btn) begin
      vs_meta <= ~VS_ACTIVE;
      vs_sync <= ~VS_ACTIVE;
      vs_prev <= ~VS_ACTIVE;
    end else begin
      vs_meta <= vsync_in;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign sram_wr_addr = head[ENT_W-1:RGB_W];
  assign sram_wr_data = {8'h00, head[RGB_W-1:0]};

endmodule

// File: tb/tb_sram_frame_writer.sv
// Testbench for sram_frame_writer: directed pixel vectors with
// hand-computed addresses feed a scoreboard queue; a monitor pops and
// compares on every granted SRAM write.
module tb_sram_frame_writer;

  logic        clk_in = 1'b0;
  logic        reset_btn;
  logic        pix_valid;
  logic        pix_ready;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [23:0] pix_rgb;
  logic        pix_last;
  logic        sram_wr_req;
  logic        sram_wr_grant;
  logic [19:0] sram_wr_addr;
  logic [31:0] sram_wr_data;
  logic        vsync_in;
  logic        wr_addr_offset;
  logic        rd_addr_offset;
  logic        frame_done;
  logic        oor_err;

  sram_frame_writer dut (
    .clk_in        (clk_in),
    .reset_btn     (reset_btn),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .pix_rgb       (pix_rgb),
    .pix_last      (pix_last),
    .sram_wr_req   (sram_wr_req),
    .sram_wr_grant (sram_wr_grant),
    .sram_wr_addr  (sram_wr_addr),
    .sram_wr_data  (sram_wr_data),
    .vsync_in      (vsync_in),
    .wr_addr_offset(wr_addr_offset),
    .rd_addr_offset(rd_addr_offset),
    .frame_done    (frame_done),
    .oor_err       (oor_err)
  );

  always #5 clk_in = ~clk_in;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   accepted = 0;
  logic exp_wr   = 1'b1;
  logic [51:0] sb [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic send(input int x, input int y, input logic [23:0] rgb, input logic last);
    int   waited = 0;
    logic [18:0] lin;
    pix_valid = 1'b1;
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    pix_rgb   = rgb;
    pix_last  = last;
    @(negedge clk_in);
    while (!pix_ready && waited < 200) begin
      @(negedge clk_in);
      waited++;
    end
    if (!pix_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: pix_ready stuck at 0 for pixel (%0d,%0d)", x, y);
    end else begin
      if (x < 800 && y < 600) begin
        lin = 19'(y * 800 + x);
        sb.push_back({exp_wr, lin, 8'h00, rgb});
      end
      accepted++;
    end
    @(posedge clk_in);
    #1;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  // Scoreboard monitor: every granted write must match the oldest expectation
  always @(negedge clk_in) begin
    if (!reset_btn && sram_wr_req && sram_wr_grant) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected",
                 sram_wr_addr, sram_wr_data);
      end else begin
        logic [51:0] e;
        e = sb.pop_front();
        check("wr_addr", 64'(sram_wr_addr), 64'(e[51:32]));
        check("wr_data", 64'(sram_wr_data), 64'(e[31:0]));
      end
    end
  end

  // Counts frame_done pulses over n cycles and returns the count
  task automatic watch_swap(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      tick();
      if (frame_done) pulses++;
    end
  endtask

  initial begin
    int pulses;
    reset_btn     = 1'b1;
    pix_valid     = 1'b0;
    pix_x         = '0;
    pix_y         = '0;
    pix_rgb       = '0;
    pix_last      = 1'b0;
    sram_wr_grant = 1'b0;
    vsync_in      = 1'b0;
    tick(3);

    // Reset values
    check("rst_ready", 64'(pix_ready), 64'd0);
    check("rst_req", 64'(sram_wr_req), 64'd0);
    check("rst_addr", 64'(sram_wr_addr), 64'd0);
    check("rst_data", 64'(sram_wr_data), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_oor", 64'(oor_err), 64'd0);
    check("rst_wr_off", 64'(wr_addr_offset), 64'd1);
    check("rst_rd_off", 64'(rd_addr_offset), 64'd0);
    reset_btn = 1'b0;
    tick(1);
    check("ready_after_rst", 64'(pix_ready), 64'd1);

    // Latency and hold-while-ungranted
    send(0, 0, 24'h112233, 1'b0);
    check("lat_req_c1", 64'(sram_wr_req), 64'd0);
    tick(1);
    check("lat_req_c2", 64'(sram_wr_req), 64'd1);
    check("lat_addr", 64'(sram_wr_addr), 64'h80000);
    check("lat_data", 64'(sram_wr_data), 64'h00112233);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("hold_addr", 64'(sram_wr_addr), 64'h80000);
      check("hold_data", 64'(sram_wr_data), 64'h00112233);
    end
    sram_wr_grant = 1'b1;
    tick(1);
    sram_wr_grant = 1'b0;
    check("req_drop", 64'(sram_wr_req), 64'd0);
    check("sb_empty_lat", 64'(sb.size()), 64'd0);

    // Corner and interior addresses with grant held high
    sram_wr_grant = 1'b1;
    send(799, 599, 24'hABCDEF, 1'b0);   // {1,479999} = 0xF52FF
    send(5, 2, 24'h445566, 1'b0);       // 2*800+5 = 1605
    tick(6);
    check("sb_empty_corner", 64'(sb.size()), 64'd0);

    // Back-pressure: 20 pixels, no grant, only 8 fit
    sram_wr_grant = 1'b0;
    accepted = 0;
    fork
      begin
        for (int i = 0; i < 20; i++)
          send(i * 3, i, {8'(i), 8'hA5, 8'(i)}, 1'b0);
      end
      begin
        tick(30);
        check("bp_accepted", 64'(accepted), 64'd8);
        check("bp_ready", 64'(pix_ready), 64'd0);
        check("bp_req", 64'(sram_wr_req), 64'd1);
        sram_wr_grant = 1'b1;
      end
    join
    tick(15);
    check("bp_total", 64'(accepted), 64'd20);
    check("sb_empty_stream", 64'(sb.size()), 64'd0);

    // Frame completion; vsync during DRAIN is ignored
    sram_wr_grant = 1'b0;
    send(10, 0, 24'h000001, 1'b0);
    send(11, 0, 24'h000002, 1'b0);
    send(12, 0, 24'h000003, 1'b0);
    send(13, 0, 24'h000004, 1'b1);
    vsync_in = 1'b1;
    tick(4);
    vsync_in = 1'b0;
    tick(4);
    check("drain_no_swap_fd", 64'(frame_done), 64'd0);
    check("drain_no_swap_wr", 64'(wr_addr_offset), 64'd1);
    check("drain_ready", 64'(pix_ready), 64'd0);
    sram_wr_grant = 1'b1;
    tick(10);
    check("waitvs_wr", 64'(wr_addr_offset), 64'd1);
    check("waitvs_rd", 64'(rd_addr_offset), 64'd0);
    check("waitvs_ready", 64'(pix_ready), 64'd0);
    check("sb_empty_frame", 64'(sb.size()), 64'd0);
    vsync_in = 1'b1;
    watch_swap(10, pulses);
    vsync_in = 1'b0;
    check("swap_pulses", 64'(pulses), 64'd1);
    check("swap_wr", 64'(wr_addr_offset), 64'd0);
    check("swap_rd", 64'(rd_addr_offset), 64'd1);
    exp_wr = 1'b0;
    tick(3);
    send(1, 1, 24'h0A0B0C, 1'b0);       // {0,801} = 0x00321
    tick(5);
    check("sb_empty_newframe", 64'(sb.size()), 64'd0);

    // Out-of-range pixels: dropped, sticky error, last still ends frame
    send(800, 0, 24'hFFFFFF, 1'b0);
    tick(1);
    check("oor_set", 64'(oor_err), 64'd1);
    send(0, 600, 24'hFFFFFF, 1'b0);
    tick(5);
    check("oor_sticky", 64'(oor_err), 64'd1);
    check("oor_no_req", 64'(sram_wr_req), 64'd0);
    send(800, 0, 24'hFFFFFF, 1'b1);
    tick(5);
    check("oor_last_ready", 64'(pix_ready), 64'd0);
    vsync_in = 1'b1;
    watch_swap(10, pulses);
    vsync_in = 1'b0;
    check("oor_swap_pulses", 64'(pulses), 64'd1);
    check("oor_swap_wr", 64'(wr_addr_offset), 64'd1);
    check("oor_swap_rd", 64'(rd_addr_offset), 64'd0);
    exp_wr = 1'b1;
    tick(3);

    // Reset with queued entries
    sram_wr_grant = 1'b0;
    for (int i = 0; i < 5; i++) send(i, 3, 24'h123456, 1'b0);
    tick(2);
    check("pre_rst_req", 64'(sram_wr_req), 64'd1);
    reset_btn = 1'b1;
    #1;
    sb.delete();
    check("mid_rst_req", 64'(sram_wr_req), 64'd0);
    check("mid_rst_wr", 64'(wr_addr_offset), 64'd1);
    check("mid_rst_rd", 64'(rd_addr_offset), 64'd0);
    check("mid_rst_oor", 64'(oor_err), 64'd0);
    check("mid_rst_ready", 64'(pix_ready), 64'd0);
    tick(2);
    reset_btn = 1'b0;
    tick(3);
    check("post_rst_req", 64'(sram_wr_req), 64'd0);
    check("post_rst_ready", 64'(pix_ready), 64'd1);
    sram_wr_grant = 1'b1;
    send(2, 0, 24'h778899, 1'b0);       // {1,2} = 0x80002
    tick(5);
    check("sb_empty_final", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
